// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU link: master FSM states, default word
// width and the opcode set understood by the remote ALU.
package uart_alu_pkg;

  localparam int WIDTH_WORD_DEF = 8;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_SEND_A   = 4'd1;
  localparam logic [3:0] ST_WAIT_A   = 4'd2;
  localparam logic [3:0] ST_SEND_B   = 4'd3;
  localparam logic [3:0] ST_WAIT_B   = 4'd4;
  localparam logic [3:0] ST_SEND_OP  = 4'd5;
  localparam logic [3:0] ST_WAIT_OP  = 4'd6;
  localparam logic [3:0] ST_WAIT_RES = 4'd7;
  localparam logic [3:0] ST_DONE     = 4'd8;

  typedef enum logic [3:0] {
    IDLE     = ST_IDLE,
    SEND_A   = ST_SEND_A,
    WAIT_A   = ST_WAIT_A,
    SEND_B   = ST_SEND_B,
    WAIT_B   = ST_WAIT_B,
    SEND_OP  = ST_SEND_OP,
    WAIT_OP  = ST_WAIT_OP,
    WAIT_RES = ST_WAIT_RES,
    DONE     = ST_DONE
  } state_e;

  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_NOR = 8'h27;

endpackage

// File: rtl/uart_alu_master_timeout_counter.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT_CYCLES-1.
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/uart_alu_master.sv
// Initiator of the UART ALU link: sends A, B and opcode through tx, then
// waits for the single result byte from rx, with a watchdog on every wait.
module uart_alu_master
  import uart_alu_pkg::*;
#(
  parameter int WIDTH_WORD     = WIDTH_WORD_DEF,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [WIDTH_WORD-1:0] i_dato_A,
  input  logic [WIDTH_WORD-1:0] i_dato_B,
  input  logic [WIDTH_WORD-1:0] i_opcode,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout,
  output logic [WIDTH_WORD-1:0] o_resultado,
  output logic                  o_tx_start,
  output logic [WIDTH_WORD-1:0] o_data_tx,
  input  logic                  i_tx_done,
  input  logic                  i_rx_done,
  input  logic [WIDTH_WORD-1:0] i_data_rx
);
  // Handshake: o_tx_start pulses one cycle with o_data_tx already valid and
  // held until i_tx_done; i_rx_done qualifies i_data_rx for that cycle only.

  state_e                state_q, state_d;
  logic [WIDTH_WORD-1:0] a_q, a_d, b_q, b_d, op_q, op_d;
  logic [WIDTH_WORD-1:0] data_tx_q, data_tx_d;
  logic [WIDTH_WORD-1:0] res_q, res_d;
  logic                  timeout_q, timeout_d;
  logic                  in_wait, expired;

  assign in_wait = (state_q == WAIT_A) || (state_q == WAIT_B) ||
                   (state_q == WAIT_OP) || (state_q == WAIT_RES);

  // Any state change restarts the count, so each WAIT_x starts from zero.
  timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (i_clock),
    .rst    (i_reset),
    .clear  (state_d != state_q),
    .enable (in_wait),
    .expired(expired)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    data_tx_d = data_tx_q;
    res_d     = res_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d       = i_dato_A;
          b_d       = i_dato_B;
          op_d      = i_opcode;
          data_tx_d = i_dato_A;
          state_d   = SEND_A;
        end
      end
      SEND_A:  state_d = WAIT_A;
      SEND_B:  state_d = WAIT_B;
      SEND_OP: state_d = WAIT_OP;
      WAIT_A: begin
        if (i_tx_done) begin
          data_tx_d = b_q;
          state_d   = SEND_B;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      WAIT_B: begin
        if (i_tx_done) begin
          data_tx_d = op_q;
          state_d   = SEND_OP;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      WAIT_OP: begin
        // A result byte racing the last tx_done is dropped with the rest.
        if (i_tx_done) begin
          state_d = WAIT_RES;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      WAIT_RES: begin
        if (i_rx_done) begin
          res_d   = i_data_rx;
          state_d = DONE;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      data_tx_q <= '0;
      res_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      data_tx_q <= data_tx_d;
      res_q     <= res_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_done      = (state_q == DONE);
  assign o_tx_start  = (state_q == SEND_A) || (state_q == SEND_B) || (state_q == SEND_OP);
  assign o_timeout   = timeout_q;
  assign o_resultado = res_q;
  assign o_data_tx   = data_tx_q;

endmodule

// File: tb/tb_uart_alu_master.sv
// Bench for uart_alu_master: the bench plays tx, rx and the remote ALU.
module tb_uart_alu_master;
  localparam int W  = 8;
  localparam int TO = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start, i_tx_done, i_rx_done;
  logic [W-1:0] i_dato_A, i_dato_B, i_opcode, i_data_rx;
  logic         o_busy, o_done, o_timeout, o_tx_start;
  logic [W-1:0] o_resultado, o_data_tx;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] prev_res;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
    int         mode;
    bit         hold;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] ops[8];

  uart_alu_master #(.WIDTH_WORD(W), .TIMEOUT_CYCLES(TO)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_start    (i_start),
    .i_dato_A   (i_dato_A),
    .i_dato_B   (i_dato_B),
    .i_opcode   (i_opcode),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_timeout  (o_timeout),
    .o_resultado(o_resultado),
    .o_tx_start (o_tx_start),
    .o_data_tx  (o_data_tx),
    .i_tx_done  (i_tx_done),
    .i_rx_done  (i_rx_done),
    .i_data_rx  (i_data_rx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Remote ALU behaviour, written straight from the opcode meanings.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      8'h20:   return a + b;
      8'h22:   return a - b;
      8'h24:   return a & b;
      8'h25:   return a | b;
      8'h26:   return a ^ b;
      8'h27:   return ~(a | b);
      8'h03:   return 8'(sa >>> b);
      8'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  // mode: 0 normal, 1 stray rx in WAIT_B, 2 start in WAIT_A, 3 no result, 4 reset in WAIT_OP
  task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                        input logic [7:0] exp_res, input int mode, input int dly,
                        input bit hold_next);
    logic [7:0] bytes[3];
    logic [7:0] r;
    bit         seen;
    int         n;
    bytes[0] = a;
    bytes[1] = b;
    bytes[2] = op;
    exp_q.delete();
    check("idle_busy", o_busy, 1'b0);
    i_dato_A = a;
    i_dato_B = b;
    i_opcode = op;
    i_start  = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
          if (o_tx_start) seen = 1'b1;
          else tick();
        end
        check("tx_start_seen", seen, 1'b1);
      end
      check("tx_start", o_tx_start, 1'b1);
      check("tx_byte", o_data_tx, bytes[k]);
      exp_q.push_back(o_data_tx);
      tick();
      check("tx_start_pulse", o_tx_start, 1'b0);
      for (int i = 1; i < dly; i++) begin
        if (mode == 2 && k == 0 && i == 3) begin
          i_start  = 1'b1;
          i_dato_A = ~a;
          i_dato_B = ~b;
          i_opcode = 8'h27;
        end
        if (mode == 1 && k == 1 && i == 3) begin
          i_rx_done = 1'b1;
          i_data_rx = 8'hFF;
        end
        tick();
        i_start   = 1'b0;
        i_rx_done = 1'b0;
      end
      check("tx_hold", o_data_tx, bytes[k]);
      check("busy_wait", o_busy, 1'b1);
      if (mode == 1 && k == 1) check("stray_res", o_resultado, prev_res);
      if (mode == 4 && k == 2) begin
        #1 rst = 1'b1;
        #1;
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_timeout", o_timeout, 1'b0);
        check("rst_res", o_resultado, 8'h00);
        check("rst_tx_start", o_tx_start, 1'b0);
        check("rst_data_tx", o_data_tx, 8'h00);
        #1 rst = 1'b0;
        tick();
        prev_res = 8'h00;
        return;
      end
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
    end
    if (mode == 3) begin
      n    = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        if (o_timeout) seen = 1'b1;
        else begin
          n++;
          tick();
        end
      end
      check("timeout_seen", seen, 1'b1);
      check("timeout_latency", n, TO);
      check("timeout_busy", o_busy, 1'b0);
      check("timeout_res", o_resultado, prev_res);
      check("timeout_no_done", o_done, 1'b0);
      tick();
      check("timeout_pulse", o_timeout, 1'b0);
      check("timeout_busy_next", o_busy, 1'b0);
      return;
    end
    repeat (4) tick();
    check("res_wait_busy", o_busy, 1'b1);
    r = alu_ref(exp_q[0], exp_q[1], exp_q[2]);
    i_data_rx = r;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
    i_data_rx = 8'($urandom);
    check("done", o_done, 1'b1);
    check("result", o_resultado, exp_res);
    check("done_busy", o_busy, 1'b1);
    if (hold_next) i_start = 1'b1;
    tick();
    check("done_pulse", o_done, 1'b0);
    check("busy_fall", o_busy, 1'b0);
    check("result_held", o_resultado, exp_res);
    prev_res = exp_res;
  endtask

  initial begin
    rst       = 1'b1;
    i_start   = 1'b0;
    i_tx_done = 1'b0;
    i_rx_done = 1'b0;
    i_dato_A  = '0;
    i_dato_B  = '0;
    i_opcode  = '0;
    i_data_rx = '0;
    prev_res  = 8'h00;

    vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 0, 1'b0};
    vecs[1]  = '{8'h05, 8'h03, 8'h22, 8'h02, 1, 1'b0};
    vecs[2]  = '{8'h11, 8'h22, 8'h20, 8'h33, 2, 1'b0};
    vecs[3]  = '{8'hF0, 8'h3C, 8'h24, 8'h30, 0, 1'b1};
    vecs[4]  = '{8'hF0, 8'h3C, 8'h25, 8'hFC, 0, 1'b0};
    vecs[5]  = '{8'hAA, 8'h0F, 8'h26, 8'hA5, 0, 1'b0};
    vecs[6]  = '{8'hF0, 8'h3C, 8'h27, 8'h03, 0, 1'b0};
    vecs[7]  = '{8'h81, 8'h01, 8'h03, 8'hC0, 0, 1'b0};
    vecs[8]  = '{8'h81, 8'h01, 8'h02, 8'h40, 0, 1'b0};
    vecs[9]  = '{8'h12, 8'h34, 8'h20, 8'h00, 3, 1'b0};
    vecs[10] = '{8'h12, 8'h34, 8'h20, 8'h00, 4, 1'b0};
    vecs[11] = '{8'h07, 8'h09, 8'h20, 8'h10, 0, 1'b0};

    ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24; ops[3] = 8'h25;
    ops[4] = 8'h26; ops[5] = 8'h03; ops[6] = 8'h02; ops[7] = 8'h27;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", o_busy, 1'b0);
    check("reset_done", o_done, 1'b0);
    check("reset_timeout", o_timeout, 1'b0);
    check("reset_res", o_resultado, 8'h00);
    check("reset_tx_start", o_tx_start, 1'b0);
    check("reset_data_tx", o_data_tx, 8'h00);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 12; v++) begin
      do_txn(vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].res, vecs[v].mode, 10, vecs[v].hold);
      if (vecs[v].mode != 0 || vecs[v].hold == 1'b0) repeat (2) tick();
    end

    for (int t = 0; t < 10; t++) begin
      logic [7:0] a, b, op;
      a  = 8'($urandom);
      b  = 8'($urandom_range(0, 7));
      op = ops[$urandom_range(0, 7)];
      do_txn(a, b, op, alu_ref(a, b, op), 0, $urandom_range(2, 15), 1'b0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
